line_streamer: RTL

Drives the line mapper and the character ROM from the consuming side. On a start request for a line index, it reads the address range for that line from the mapper, fetches each 16-bit two-character word from the ROM, and emits the characters one byte at a time on a valid/ready byte stream. The stream feeds the display/serial output stage. The block owns the `line` input of the mapper and the `addr` input of the ROM.

---
 rtl/line_streamer.sv | 118 +++++++++++
 1 files changed

// File: rtl/line_streamer.sv
// Streams one text line as bytes: asks the mapper for the line's word range,
// fetches each 16-bit word from the character ROM, and emits high then low byte.
module line_streamer #(
  parameter int MAP_LAT = 1,
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  line_sel,
  output logic [7:0]  map_line,
  input  logic [15:0] map_range,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic        busy,
  output logic        done,
  output logic        range_err
);

  typedef enum logic [2:0] {IDLE, MAP, FETCH, SEND_HI, SEND_LO} state_t;

  localparam logic [1:0] MAP_END = 2'(MAP_LAT);
  localparam logic [1:0] ROM_END = 2'(ROM_LAT);

  state_t     state;
  logic [1:0] cnt;
  logic [7:0] last;
  logic [7:0] word_lo;

  // The high byte goes straight into tdata at fetch time, so only the low
  // byte of the word needs its own register until SEND_LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      word_lo   <= '0;
      map_line  <= '0;
      rom_addr  <= '0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      range_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            map_line <= line_sel;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= MAP;
          end
        end
        MAP: begin
          if (cnt == MAP_END) begin
            cnt  <= '0;
            last <= map_range[15:8];
            if (map_range[15:8] < map_range[7:0]) begin
              done      <= 1'b1;
              range_err <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rom_addr <= map_range[7:0];
              state    <= FETCH;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        FETCH: begin
          if (cnt == ROM_END) begin
            cnt     <= '0;
            tdata   <= rom_data[15:8];
            word_lo <= rom_data[7:0];
            tvalid  <= 1'b1;
            tlast   <= 1'b0;
            state   <= SEND_HI;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        SEND_HI: begin
          if (tready) begin
            tdata <= word_lo;
            tlast <= (rom_addr == last);
            state <= SEND_LO;
          end
        end
        SEND_LO: begin
          // Equality against last (never a magnitude test) lets 0xFF end a line without wrapping.
          if (tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            if (rom_addr == last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
